// File: rtl/vga_fb_reader.sv
// Framebuffer reader: 800x600@60 VGA timing, line-doubled 800x240 1-bpp window
// centred vertically, monochrome output with a tint latched once per frame.
module vga_fb_reader #(
  parameter int H_VISIBLE   = 800,
  parameter int H_FP        = 40,
  parameter int H_SYNC      = 128,
  parameter int H_BP        = 88,
  parameter int V_VISIBLE   = 600,
  parameter int V_FP        = 1,
  parameter int V_SYNC      = 4,
  parameter int V_BP        = 23,
  parameter int FB_WIDTH    = 800,
  parameter int FB_LINES    = 240,
  parameter int V_OFFSET    = 60,
  parameter int RAM_LATENCY = 2
) (
  input  logic        vgaclk,
  input  logic        reset,
  output logic [17:0] raddr,
  input  logic        rdata,
  input  logic [1:0]  color_sel,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        blank,
  output logic        frame_start
);

  localparam int STAGES  = RAM_LATENCY + 1;
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT   = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_BEG  = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END  = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0]  WIN_BEG = 10'(V_OFFSET);
  localparam logic [9:0]  WIN_END = 10'(V_OFFSET + 2 * FB_LINES);
  localparam logic [17:0] FB_W    = 18'(FB_WIDTH);

  function automatic logic [11:0] tint_rgb(input logic [1:0] sel);
    case (sel)
      2'b01:   return 12'h0F0;
      2'b10:   return 12'hFB0;
      default: return 12'hFFF;
    endcase
  endfunction

  // Two display lines share one framebuffer row; 800 = 512 + 256 + 32.
  function automatic logic [17:0] fb_addr(input logic [9:0] v, input logic [10:0] h);
    logic [9:0]  line_off;
    logic [17:0] row;
    line_off = v - WIN_BEG;
    row      = {9'd0, line_off[9:1]};
    if (FB_WIDTH == 800)
      return (row << 9) + (row << 8) + (row << 5) + {7'd0, h};
    else
      return row * FB_W + {7'd0, h};
  endfunction

  logic [10:0] hcount_p0;
  logic [9:0]  vcount_p0;
  logic        active_p0, hs_p0, vs_p0, win_p0, frame_p0;
  logic [4:0]  ctl_p [STAGES];
  logic [1:0]  tint;
  logic        win_out, active_out;

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      hcount_p0 <= '0;
      vcount_p0 <= '0;
    end else if (hcount_p0 == H_LAST) begin
      hcount_p0 <= '0;
      vcount_p0 <= (vcount_p0 == V_LAST) ? 10'd0 : vcount_p0 + 10'd1;
    end else begin
      hcount_p0 <= hcount_p0 + 11'd1;
    end
  end

  always_comb begin
    active_p0 = (hcount_p0 < H_ACT) && (vcount_p0 < V_ACT);
    hs_p0     = (hcount_p0 >= HS_BEG) && (hcount_p0 < HS_END);
    vs_p0     = (vcount_p0 >= VS_BEG) && (vcount_p0 < VS_END);
    win_p0    = active_p0 && (vcount_p0 >= WIN_BEG) && (vcount_p0 < WIN_END);
    frame_p0  = (hcount_p0 == 11'd0) && (vcount_p0 == 10'd0);
  end

  // ---- counter stage -> address register / control delay line ----
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      raddr <= '0;
      tint  <= 2'b00;
      for (int i = 0; i < STAGES; i++) ctl_p[i] <= '0;
    end else begin
      raddr    <= win_p0 ? fb_addr(vcount_p0, hcount_p0) : 18'd0;
      ctl_p[0] <= {frame_p0, win_p0, active_p0, vs_p0, hs_p0};
      for (int i = 1; i < STAGES; i++) ctl_p[i] <= ctl_p[i-1];
      if (frame_p0) tint <= color_sel;
    end
  end

  // ---- output stage: control aligned with rdata of the same position ----
  assign {frame_start, win_out, active_out, vga_vsync, vga_hsync} = ctl_p[STAGES-1];
  assign blank = ~active_out;

  always_comb begin
    {vga_r, vga_g, vga_b} = 12'h000;
    if (win_out && rdata) {vga_r, vga_g, vga_b} = tint_rgb(tint);
  end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
- Reader side of the dual-port framebuffer RAM. The capture block writes TRS-80 Model 4 pixels into this RAM.
- Generates 800x600@60 Hz VGA timing from the VGA pixel clock.
- Fetches 1-bit pixels from the 800x240 framebuffer (addresses 0..191999) and line-doubles them into a 480-line window centred vertically.
- Drives monochrome RGB with a selectable phosphor tint.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FP, 40, horizontal front porch clocks
- H_SYNC, 128, hsync pulse clocks
- H_BP, 88, horizontal back porch clocks (line total 1056)
- V_VISIBLE, 600, active lines
- V_FP, 1, vertical front porch lines
- V_SYNC, 4, vsync pulse lines
- V_BP, 23, vertical back porch lines (frame total 628)
- FB_WIDTH, 800, framebuffer pixels per row
- FB_LINES, 240, framebuffer rows
- V_OFFSET, 60, first display line of the framebuffer window
- RAM_LATENCY, 2, clocks from raddr registered to rdata valid

Ports:
- vgaclk  input  1  VGA pixel clock, 40 MHz
- reset  input  1  asynchronous, active-high reset
- raddr  output  18  framebuffer read address
- rdata  input  1  framebuffer pixel (1 = lit)
- color_sel  input  2  tint: 00 white, 01 green, 10 amber, 11 white
- vga_hsync  output  1  horizontal sync, active high
- vga_vsync  output  1  vertical sync, active high
- vga_r  output  4  red
- vga_g  output  4  green
- vga_b  output  4  blue
- blank  output  1  high outside the 800x600 active area
- frame_start  output  1  one-clock pulse aligned with the first output pixel (0,0)

Behaviour:

Reset (async assert, sync release):
- hcount and vcount = 0.
- raddr = 0; vga_hsync, vga_vsync, frame_start = 0; blank = 1; vga_r/g/b = 0.
- Latched tint = white. Delay pipeline cleared to the blank/inactive state.

Counters:
- hcount runs 0..1055 and wraps to 0.
- vcount increments when hcount wraps, runs 0..627, and wraps to 0.

Timing decode at counter stage:
- Active = hcount < 800 && vcount < 600.
- hsync_pre = 840 <= hcount < 968.
- vsync_pre = 601 <= vcount < 605.

Framebuffer window:
- in_win = active && 60 <= vcount < 540.
- fb_row = (vcount - 60) >> 1, so display lines 2k+60 and 2k+61 both show row k.
- Address = fb_row*800 + hcount. Multiply via shifts: (r<<9)+(r<<8)+(r<<5). Result truncated to 18 bits; maximum value 191999.
- raddr is registered: raddr = address when in_win, else 0.

Output alignment:
- Outputs for counter position (h,v) appear exactly RAM_LATENCY+1 clocks after the counters hold (h,v).
- hsync_pre, vsync_pre, active, in_win and frame_pre (h==0 && v==0) pass through a delay line of RAM_LATENCY+1 stages.

Colour output:
- Pixel lit when delayed in_win && rdata.
- Lit white = F/F/F; green = 0/F/0; amber = F/B/0.
- Unlit, outside the window, or blank: all channels 0.
- blank = !delayed active.

Tint latch:
- color_sel is sampled only when hcount==0 && vcount==0.
- A change mid-frame takes effect from the next frame. No tearing.

Boundaries:
- Last window line 539 reads row 239 (base 191200).
- Display lines 0..59 and 540..599 are black with raddr 0.
- rdata is ignored whenever the delayed in_win is low.

Reset mid-frame:
- Takes effect immediately (async).
- After release, the counters restart at (0,0) and the first frame_start follows RAM_LATENCY+1 clocks later.

Test Plan:
- Reset then run 1056 clocks: vga_hsync high for exactly 128 clocks, rising 843 clocks after release (840+3); line period 1056.
- Run a full frame: vga_vsync high for 4 lines (4224 clocks); frame period 663168 clocks; frame_start exactly once per frame.
- RAM model (latency 2, rdata = addr[0]):
  - Display line 60 and line 61, pixel 5: raddr = 5 on both lines.
  - Line 539, pixel 799: raddr = 191999.
  - Output at pixel 5 of line 60 is lit with the correct 3-clock alignment.
  - Lines 0..59 and 540..599 are fully black.
- color_sel=01 set mid-frame: the current frame stays white (F/F/F); the next frame's lit pixels are 0/F/0. color_sel=10 gives F/B/0.
- Horizontal blank (hcount 800..1055) with rdata forced 1: blank=1 and RGB=0 throughout; raddr=0.
- Assert reset at line 300: outputs go to reset values immediately; after release, counters restart and frame_start fires 3 clocks after release.
